// File: rtl/ring_pkg.sv
// Shared types and helpers for one-hot ring consumers.
package ring_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } ring_state_e;

    typedef enum logic [1:0] {
        FWD  = 2'd0,
        BWD  = 2'd1,
        HOLD = 2'd2,
        JUMP = 2'd3
    } step_class_e;

    // Below 3 bits the +1 and -1 neighbours coincide, so direction is meaningless.
    function automatic bit width_ok(int unsigned w);
        return (w >= 3) && (w <= 256);
    endfunction

endpackage

// File: rtl/onehot_encoder.sv
// Combinational one-hot to binary encoder with a legality flag.
module onehot_encoder #(
    parameter int unsigned width = 32
) (
    input  logic [width-1:0]         value,
    output logic [$clog2(width)-1:0] index,
    output logic                     is_onehot
);
    localparam int unsigned iw = $clog2(width);
    localparam logic [width-1:0] ONE = width'(1);

    logic [iw-1:0] w_index;

    // OR of set-bit indices; exact whenever the input is one-hot.
    always_comb begin
        w_index = '0;
        for (int i = 0; i < int'(width); i++) begin
            if (value[i]) begin
                w_index = w_index | iw'(i);
            end
        end
    end

    assign index     = w_index;
    assign is_onehot = (value != '0) && ((value & (value - ONE)) == '0);

endmodule

// File: rtl/ring_position_decoder.sv
// Decodes a sampled one-hot ring to a position, tracks rotation direction and counts errors.
module ring_position_decoder
    import ring_pkg::*;
#(
    parameter int unsigned width = 32,
    parameter int unsigned err_w = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sample_en,
    input  logic [width-1:0]         ring_value,
    input  logic                     clear_err,
    output logic [$clog2(width)-1:0] position,
    output logic                     dir,
    output logic                     locked,
    output logic                     step_err,
    output logic [err_w-1:0]         err_count
);
    localparam int unsigned iw = $clog2(width);
    localparam logic [iw-1:0] LAST = iw'(width - 1);
    localparam logic [err_w-1:0] CNT_MAX = '1;

    if (!width_ok(width)) begin : g_bad_width
        $error("ring_position_decoder: width must be in 3..256");
    end

    ring_state_e      r_state, w_state_next;
    logic [iw-1:0]    r_position, w_position_next;
    logic             r_dir, w_dir_next;
    logic             r_locked;
    logic             r_step_err, w_step_err_next;
    logic [err_w-1:0] r_err_count, w_err_count_next;

    logic [iw-1:0] w_index;
    logic          w_is_onehot;
    logic [iw-1:0] w_up, w_dn;
    step_class_e   w_class;

    onehot_encoder #(
        .width (width)
    ) u_encoder (
        .value     (ring_value),
        .index     (w_index),
        .is_onehot (w_is_onehot)
    );

    assign w_up = (r_position == LAST) ? '0 : r_position + iw'(1);
    assign w_dn = (r_position == '0) ? LAST : r_position - iw'(1);

    always_comb begin
        w_class = JUMP;
        if (w_index == r_position) begin
            w_class = HOLD;
        end else if (w_index == w_up) begin
            w_class = FWD;
        end else if (w_index == w_dn) begin
            w_class = BWD;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_position_next = r_position;
        w_dir_next      = r_dir;
        w_step_err_next = 1'b0;
        if (sample_en) begin
            case (r_state)
                IDLE: begin
                    if (w_is_onehot) begin
                        w_position_next = w_index;
                        w_state_next    = ACQUIRE;
                    end else begin
                        w_step_err_next = 1'b1;
                    end
                end
                ACQUIRE: begin
                    if (!w_is_onehot) begin
                        w_step_err_next = 1'b1;
                        w_state_next    = IDLE;
                    end else begin
                        unique case (w_class)
                            FWD, BWD: begin
                                w_position_next = w_index;
                                w_dir_next      = (w_class == FWD);
                                w_state_next    = LOCKED;
                            end
                            JUMP: begin
                                w_position_next = w_index;
                                w_step_err_next = 1'b1;
                            end
                            HOLD: begin
                                w_step_err_next = 1'b1;
                                w_state_next    = IDLE;
                            end
                        endcase
                    end
                end
                LOCKED: begin
                    if (!w_is_onehot) begin
                        // Position keeps the last good value for downstream logic.
                        w_step_err_next = 1'b1;
                        w_state_next    = IDLE;
                    end else if (w_class == FWD || w_class == BWD) begin
                        w_position_next = w_index;
                        w_dir_next      = (w_class == FWD);
                    end else begin
                        w_position_next = w_index;
                        w_step_err_next = 1'b1;
                        w_state_next    = ACQUIRE;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        w_err_count_next = r_err_count;
        if (clear_err) begin
            w_err_count_next = '0;
        end else if (w_step_err_next && r_err_count != CNT_MAX) begin
            w_err_count_next = r_err_count + err_w'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_position  <= '0;
            r_dir       <= 1'b1;
            r_locked    <= 1'b0;
            r_step_err  <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_state     <= w_state_next;
            r_position  <= w_position_next;
            r_dir       <= w_dir_next;
            r_locked    <= (w_state_next == LOCKED);
            r_step_err  <= w_step_err_next;
            r_err_count <= w_err_count_next;
        end
    end

    assign position  = r_position;
    assign dir       = r_dir;
    assign locked    = r_locked;
    assign step_err  = r_step_err;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_ring_position_decoder.sv
// Bench for ring_position_decoder: directed table, corner sequences, random vs reference model.
module tb_ring_position_decoder;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         sample_en;
    logic [W-1:0] ring_value;
    logic         clear_err;
    logic [2:0]   position, s_position;
    logic         dir, s_dir, locked, s_locked, step_err, s_step_err;
    logic [7:0]   err_count;
    logic [1:0]   s_err_count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: 0 = idle, 1 = acquire, 2 = locked.
    int m_state, m_pos, m_cnt, m_scnt;
    bit m_dir, m_lk, m_se;

    typedef struct {
        bit         en;
        logic [7:0] val;
        bit         clr;
        int         pos;
        bit         dir;
        bit         lk;
        bit         se;
        int         cnt;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    ring_position_decoder #(
        .width (W),
        .err_w (8)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .sample_en  (sample_en),
        .ring_value (ring_value),
        .clear_err  (clear_err),
        .position   (position),
        .dir        (dir),
        .locked     (locked),
        .step_err   (step_err),
        .err_count  (err_count)
    );

    ring_position_decoder #(
        .width (W),
        .err_w (2)
    ) u_sat (
        .clk        (clk),
        .reset      (reset),
        .sample_en  (sample_en),
        .ring_value (ring_value),
        .clear_err  (clear_err),
        .position   (s_position),
        .dir        (s_dir),
        .locked     (s_locked),
        .step_err   (s_step_err),
        .err_count  (s_err_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        n_checks++;
        if (act !== 32'(exp)) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_pos = 0; m_dir = 1'b1; m_lk = 1'b0; m_se = 1'b0;
        m_cnt = 0; m_scnt = 0;
    endtask

    task automatic model_step(input bit en, input logic [7:0] v, input bit clr);
        int  p = 0;
        int  d;
        bit  legal;
        legal = ($countones(v) == 1);
        for (int i = 0; i < W; i++) if (v[i]) p = i;
        m_se = 1'b0;
        if (en) begin
            d = (p - m_pos + W) % W;
            case (m_state)
                0: if (legal) begin m_pos = p; m_state = 1; end else m_se = 1'b1;
                1: begin
                    if (!legal || d == 0) begin m_se = 1'b1; m_state = 0; end
                    else if (d == 1 || d == W - 1) begin
                        m_dir = (d == 1); m_pos = p; m_state = 2;
                    end else begin m_pos = p; m_se = 1'b1; end
                end
                default: begin
                    if (!legal) begin m_se = 1'b1; m_state = 0; end
                    else if (d == 1 || d == W - 1) begin m_dir = (d == 1); m_pos = p; end
                    else begin m_se = 1'b1; m_pos = p; m_state = 1; end
                end
            endcase
        end
        m_lk = (m_state == 2);
        if (clr) begin
            m_cnt = 0; m_scnt = 0;
        end else if (m_se) begin
            m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
            m_scnt = (m_scnt < 3) ? m_scnt + 1 : 3;
        end
    endtask

    task automatic drive(input bit en, input logic [7:0] v, input bit clr);
        @(negedge clk);
        sample_en  = en;
        ring_value = v;
        clear_err  = clr;
        @(posedge clk);
        model_step(en, v, clr);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; sample_en = 1'b0; ring_value = '0; clear_err = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, " position"}, position, m_pos);
        chk({tag, " dir"}, dir, m_dir);
        chk({tag, " locked"}, locked, m_lk);
        chk({tag, " step_err"}, step_err, m_se);
        chk({tag, " err_count"}, err_count, m_cnt);
        chk({tag, " sat position"}, s_position, m_pos);
        chk({tag, " sat err_count"}, s_err_count, m_scnt);
    endtask

    task automatic add(input bit en, input logic [7:0] v, input bit clr, input int pos,
                       input bit d, input bit lk, input bit se, input int cnt);
        vec_t t;
        t.en = en; t.val = v; t.clr = clr; t.pos = pos;
        t.dir = d; t.lk = lk; t.se = se; t.cnt = cnt;
        tbl.push_back(t);
    endtask

    initial begin
        logic [7:0] v;
        int         r;

        reset = 1'b0; sample_en = 1'b0; ring_value = '0; clear_err = 1'b0;
        // Acquire and lock forward, walk round the forward wrap, then reverse.
        add(1, 8'h01, 0, 0, 1, 0, 0, 0);
        add(1, 8'h02, 0, 1, 1, 1, 0, 0);
        add(1, 8'h04, 0, 2, 1, 1, 0, 0);
        add(1, 8'h08, 0, 3, 1, 1, 0, 0);
        add(1, 8'h10, 0, 4, 1, 1, 0, 0);
        add(1, 8'h20, 0, 5, 1, 1, 0, 0);
        add(1, 8'h40, 0, 6, 1, 1, 0, 0);
        add(1, 8'h80, 0, 7, 1, 1, 0, 0);
        add(1, 8'h01, 0, 0, 1, 1, 0, 0);
        add(1, 8'h80, 0, 7, 0, 1, 0, 0);
        add(1, 8'h40, 0, 6, 0, 1, 0, 0);
        add(1, 8'h20, 0, 5, 0, 1, 0, 0);
        add(1, 8'h10, 0, 4, 0, 1, 0, 0);
        add(1, 8'h08, 0, 3, 0, 1, 0, 0);
        add(1, 8'h04, 0, 2, 0, 1, 0, 0);
        // Hold while locked, then relock forward.
        add(1, 8'h04, 0, 2, 0, 0, 1, 1);
        add(1, 8'h08, 0, 3, 1, 1, 0, 1);
        // Zero word, then a two-hot word, then relock backward.
        add(1, 8'h00, 0, 3, 1, 0, 1, 2);
        add(1, 8'h12, 0, 3, 1, 0, 1, 3);
        add(1, 8'h10, 0, 4, 1, 0, 0, 3);
        add(1, 8'h08, 0, 3, 0, 1, 0, 3);
        // Strobe low holds; clear without a sample.
        add(0, 8'h40, 0, 3, 0, 1, 0, 3);
        add(0, 8'h00, 1, 3, 0, 1, 0, 0);
        // Jump while locked, jump while acquiring, backward lock, error with clear.
        add(1, 8'h80, 0, 7, 0, 0, 1, 1);
        add(1, 8'h02, 0, 1, 0, 0, 1, 2);
        add(1, 8'h01, 0, 0, 0, 1, 0, 2);
        add(1, 8'h00, 1, 0, 0, 0, 1, 0);

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset position", position, 0);
        chk("reset dir", dir, 1);
        chk("reset locked", locked, 0);
        chk("reset step_err", step_err, 0);
        chk("reset err_count", err_count, 0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].en, tbl[i].val, tbl[i].clr);
            chk($sformatf("vec%0d position", i), position, tbl[i].pos);
            chk($sformatf("vec%0d dir", i), dir, tbl[i].dir);
            chk($sformatf("vec%0d locked", i), locked, tbl[i].lk);
            chk($sformatf("vec%0d step_err", i), step_err, tbl[i].se);
            chk($sformatf("vec%0d err_count", i), err_count, tbl[i].cnt);
        end

        // Saturation on the 2-bit counter, then clear beating a simultaneous error.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1, 8'h00, 0);
            chk($sformatf("sat%0d sat err_count", i), s_err_count, (i + 1 < 3) ? i + 1 : 3);
            chk($sformatf("sat%0d err_count", i), err_count, i + 1);
        end
        drive(1, 8'h00, 1);
        chk("sat clear step_err", s_step_err, 1);
        chk("sat clear sat err_count", s_err_count, 0);
        chk("sat clear err_count", err_count, 0);

        // Asynchronous reset while locked with dir=0 and a nonzero count.
        do_reset();
        drive(1, 8'h01, 0);
        drive(1, 8'h02, 0);
        drive(1, 8'h01, 0);
        drive(1, 8'h01, 0);
        drive(1, 8'h80, 0);
        chk("pre-areset locked", locked, 1);
        chk("pre-areset dir", dir, 0);
        chk("pre-areset err_count", err_count, 1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("areset position", position, 0);
        chk("areset dir", dir, 1);
        chk("areset locked", locked, 0);
        chk("areset err_count", err_count, 0);
        chk("areset sat dir", s_dir, 1);
        model_reset();
        sample_en = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        drive(1, 8'h20, 0);
        chk("post-areset position", position, 5);
        chk("post-areset locked", locked, 0);
        chk("post-areset step_err", step_err, 0);
        drive(1, 8'h40, 0);
        chk("post-areset relock", locked, 1);
        chk("post-areset relock sat", s_locked, 1);

        // Random walk against the reference model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 40)      v = 8'(1) << ((m_pos + 1) % W);
            else if (r < 65) v = 8'(1) << ((m_pos + W - 1) % W);
            else if (r < 75) v = 8'(1) << m_pos;
            else if (r < 85) v = 8'(1) << $urandom_range(0, W - 1);
            else             v = 8'($urandom_range(0, 255));
            drive($urandom_range(0, 9) != 0, v, $urandom_range(0, 29) == 0);
            check_model($sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ring_position_decoder.md
Name: ring_position_decoder

Overview:
Receive-side companion to the team's one-hot ring shift register. Samples a width-bit one-hot ring value and checks that it is legal. Encodes the value to a binary position, infers the rotation direction and locks onto a consistent rotation. Flags and counts illegal codes and illegal jumps, for use by downstream position logic and debug counters.

Parameters:
width, 32, ring width in bits; legal range 3..256 (for width 2, the +1 and -1 steps are indistinguishable).
err_w, 8, width of the saturating error counter.
(localparam) iw = $clog2(width), width of the position output.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
sample_en  input  1  strobe: ring_value is sampled on this clk edge
ring_value  input  width  one-hot ring word; bit i set = position i
clear_err  input  1  synchronous clear of err_count
position  output  iw  binary index of the last legal sample
dir  output  1  1 = rotating toward higher index (shift left), 0 = toward lower index
locked  output  1  high while in the LOCKED state
step_err  output  1  one-cycle pulse on an illegal sample
err_count  output  err_w  saturating count of step_err pulses

Behaviour:
- Reset (reset=0, async): state=IDLE, position=0, dir=1, locked=0, step_err=0, err_count=0.
- All outputs are registered. The response to a sample appears on the clk edge where sample_en=1, i.e. visible in the next cycle. When sample_en=0, the state holds and step_err=0.
- Legal code: exactly one bit set. Position p = index of the set bit.
- Step classification relative to the stored position q, all mod width:
  - fwd: p = q+1 (width-1 -> 0 is fwd).
  - bwd: p = q-1 (0 -> width-1 is bwd).
  - hold: p = q.
  - jump: any other p.
- States:
  - IDLE:
    - legal sample: position<=p; go to ACQUIRE.
    - illegal sample: step_err pulse; stay in IDLE.
  - ACQUIRE:
    - fwd or bwd: position<=p; dir<=(fwd); go to LOCKED; locked=1.
    - jump: position<=p; step_err pulse; stay in ACQUIRE.
    - hold or illegal code: step_err pulse; go to IDLE.
  - LOCKED:
    - fwd or bwd: position<=p; dir<=(fwd). A reversal is legal and is not an error; the ring direction may change at any time.
    - hold or jump (legal code): step_err pulse; position<=p; go to ACQUIRE; locked=0.
    - illegal code (zero bits or more than one bit set): step_err pulse; go to IDLE; locked=0; position holds its last value.
- err_count:
  - Increments on each step_err and saturates at 2^err_w-1.
  - clear_err has priority over a simultaneous increment: result is 0.
- In IDLE, dir holds its last value.
- A reset assertion at any point forces the reset values immediately. The first sample after reset deasserts is treated as an IDLE sample.

Decomposition:
- Package ring_pkg:
  - state enum {IDLE, ACQUIRE, LOCKED};
  - step-class enum {FWD, BWD, HOLD, JUMP};
  - width legality check function.
- Sub-module onehot_encoder (combinational, width parameter): outputs index[iw-1:0] and is_onehot. It is reused by other ring consumers.
- The top level contains the step classifier, the FSM and the error counter.

Test Plan:
- width=8, reset, then samples 0x01,0x02,0x04 -> after the 2nd sample locked=1, dir=1, position=1; after the 3rd, position=2, step_err never pulses.
- Locked forward, samples 0x40,0x80,0x01 -> position 6,7,0, dir=1, locked stays 1 (forward wrap). Then 0x80 -> position=7, dir=0, no error (reversal).
- Locked at position 2, sample 0x04 (hold) -> step_err pulse, err_count=1, locked=0, state ACQUIRE. Then 0x08 -> relocked, position=3, dir=1.
- Locked, samples 0x00 and then 0x12 -> two step_err pulses, err_count+2, state IDLE, position unchanged. Then 0x10,0x08 -> locked, dir=0.
- err_w=2: 5 illegal samples -> err_count saturates at 3. clear_err in the same cycle as a 6th error -> err_count=0.
- Locked mid-rotation, assert reset asynchronously between edges -> outputs drop to reset values without waiting for a clock edge. Release reset; the first sample 0x20 -> ACQUIRE, position=5, locked=0.
